win_3x3_gen: RTL and testbench



---
 rtl/img_proc_pkg.sv | 18 +
 rtl/axi4_stream_if.sv | 29 ++
 rtl/win_3x3_gen_stream_join3.sv | 40 ++++
 rtl/win_3x3_gen.sv | 164 ++++++++++++++++
 tb/tb_win_3x3_gen.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/img_proc_pkg.sv
// Shared definitions for the 3x3 window path: window FSM states and
// the row/column -> pixel-slot mapping used when packing a window.
package img_proc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } win_state_e;

   localparam int WIN_SIZE = 3;

   // Slot of pixel (r, c) inside a packed window; r=0 is top, c=0 is left.
   function automatic int win_idx(input int r, input int c);
      return r * WIN_SIZE + c;
   endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-Stream bundle (tvalid/tready/tdata/tuser/tlast) with
// master and slave views.
interface axi4_stream_if #(
   parameter int DATA_W = 32
) ();

   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic              tuser;
   logic              tlast;

   modport master (
      output tvalid,
      output tdata,
      output tuser,
      output tlast,
      input  tready
   );

   modport slave (
      input  tvalid,
      input  tdata,
      input  tuser,
      input  tlast,
      output tready
   );

endinterface

// File: rtl/win_3x3_gen_stream_join3.sv
// Three-way valid/ready join for the row streams plus a registered pulse
// flagging beats whose outer-row tlast disagrees with the centre row.
module stream_join3 (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic vld0_i,
   input  logic vld1_i,
   input  logic vld2_i,
   input  logic last0_i,
   input  logic last1_i,
   input  logic last2_i,
   input  logic en_i,
   output logic rdy_o,
   output logic accept_o,
   output logic desync_o
);

   logic all_valid;
   logic desync_d;
   logic desync_q;

   // Ready never depends on valid, so all three rows see the same tready.
   always_comb begin
      all_valid = vld0_i & vld1_i & vld2_i;
      rdy_o     = en_i;
      accept_o  = all_valid & en_i;
      desync_d  = accept_o & ((last0_i ^ last1_i) | (last2_i ^ last1_i));
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         desync_q <= 1'b0;
      end else begin
         desync_q <= desync_d;
      end
   end

   assign desync_o = desync_q;

endmodule

// File: rtl/win_3x3_gen.sv
// Builds one 3x3 window per centre pixel from three row-aligned streams,
// replicating the edge column at both horizontal borders of each line.
module win_3x3_gen
   import img_proc_pkg::*;
#(
   parameter int PX_WIDTH        = 30,
   parameter int TDATA_WIDTH     = 32,
   parameter int WIN_TDATA_WIDTH = 272
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   axi4_stream_if.slave  row0_i,
   axi4_stream_if.slave  row1_i,
   axi4_stream_if.slave  row2_i,
   axi4_stream_if.master win_o,
   output logic          desync_o
);

   typedef logic [WIN_SIZE-1:0][PX_WIDTH-1:0]             col_t;
   typedef logic [WIN_SIZE*WIN_SIZE-1:0][PX_WIDTH-1:0]    px9_t;
   typedef logic [WIN_TDATA_WIDTH-1:0]                    win_t;

   function automatic win_t pack_win(input col_t left, input col_t centre, input col_t right);
      px9_t p;
      p = '0;
      for (int r = 0; r < WIN_SIZE; r++) begin
         p[4'(win_idx(r, 0))] = left[2'(r)];
         p[4'(win_idx(r, 1))] = centre[2'(r)];
         p[4'(win_idx(r, 2))] = right[2'(r)];
      end
      return win_t'(p);
   endfunction

   win_state_e state_q, state_d;
   col_t       l_q, l_d;
   col_t       c_q, c_d;
   logic       sof_q, sof_d;
   logic       vld_q, vld_d;
   logic       user_q, user_d;
   logic       last_q, last_d;
   win_t       data_q, data_d;

   col_t       col;
   logic       out_free;
   logic       join_en;
   logic       join_rdy;
   logic       accept;
   logic       unused_bits;

   assign col = {row2_i.tdata[PX_WIDTH-1:0],
                 row1_i.tdata[PX_WIDTH-1:0],
                 row0_i.tdata[PX_WIDTH-1:0]};

   assign out_free = ~vld_q | win_o.tready;
   assign join_en  = (state_q != FLUSH) & out_free;

   stream_join3 u_join (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .vld0_i   (row0_i.tvalid),
      .vld1_i   (row1_i.tvalid),
      .vld2_i   (row2_i.tvalid),
      .last0_i  (row0_i.tlast),
      .last1_i  (row1_i.tlast),
      .last2_i  (row2_i.tlast),
      .en_i     (join_en),
      .rdy_o    (join_rdy),
      .accept_o (accept),
      .desync_o (desync_o)
   );

   assign row0_i.tready = join_rdy;
   assign row1_i.tready = join_rdy;
   assign row2_i.tready = join_rdy;

   // Only the centre row frames lines; outer tuser and upper tdata bits are don't-care.
   assign unused_bits = ^{row0_i.tdata[TDATA_WIDTH-1:PX_WIDTH],
                          row1_i.tdata[TDATA_WIDTH-1:PX_WIDTH],
                          row2_i.tdata[TDATA_WIDTH-1:PX_WIDTH],
                          row0_i.tuser, row2_i.tuser};

   always_comb begin
      state_d = state_q;
      l_d     = l_q;
      c_d     = c_q;
      sof_d   = sof_q;
      vld_d   = vld_q & ~win_o.tready;
      user_d  = user_q;
      last_d  = last_q;
      data_d  = data_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               l_d     = col;
               c_d     = col;
               sof_d   = row1_i.tuser;
               state_d = row1_i.tlast ? FLUSH : RUN;
            end
         end
         RUN: begin
            if (accept) begin
               if (row1_i.tuser) begin
                  // Frame restart: drop the open line and seed a fresh left edge.
                  l_d     = col;
                  c_d     = col;
                  sof_d   = 1'b1;
                  state_d = row1_i.tlast ? FLUSH : RUN;
               end else begin
                  data_d  = pack_win(l_q, c_q, col);
                  vld_d   = 1'b1;
                  user_d  = sof_q;
                  last_d  = 1'b0;
                  sof_d   = 1'b0;
                  l_d     = c_q;
                  c_d     = col;
                  state_d = row1_i.tlast ? FLUSH : RUN;
               end
            end
         end
         FLUSH: begin
            if (out_free) begin
               data_d  = pack_win(l_q, c_q, c_q);
               vld_d   = 1'b1;
               user_d  = sof_q;
               last_d  = 1'b1;
               sof_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         l_q     <= '0;
         c_q     <= '0;
         sof_q   <= 1'b0;
         vld_q   <= 1'b0;
         user_q  <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         l_q     <= l_d;
         c_q     <= c_d;
         sof_q   <= sof_d;
         vld_q   <= vld_d;
         user_q  <= user_d;
         last_q  <= last_d;
         data_q  <= data_d;
      end
   end

   assign win_o.tvalid = vld_q;
   assign win_o.tdata  = data_q;
   assign win_o.tuser  = user_q;
   assign win_o.tlast  = last_q;

endmodule

// File: tb/tb_win_3x3_gen.sv
// Directed bench for win_3x3_gen: border replication, framing, desync,
// mid-line restart, async reset, and a gap/backpressure run on full lines.
module tb_win_3x3_gen;

   typedef logic [273:0] cv_t;
   typedef struct packed { logic u; logic l; logic [271:0] d; } win_rec_t;

   localparam int LINE_N = 1920;

   logic clk;
   logic rst_n;
   logic desync;

   int n_cmp = 0;
   int n_bad = 0;
   bit rand_on = 0;

   win_rec_t q[$];
   logic     stall_prev;
   cv_t      prev_out;

   axi4_stream_if #(.DATA_W(32))  r0 ();
   axi4_stream_if #(.DATA_W(32))  r1 ();
   axi4_stream_if #(.DATA_W(32))  r2 ();
   axi4_stream_if #(.DATA_W(272)) wo ();

   win_3x3_gen #(
      .PX_WIDTH        (30),
      .TDATA_WIDTH     (32),
      .WIN_TDATA_WIDTH (272)
   ) dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .row0_i   (r0),
      .row1_i   (r1),
      .row2_i   (r2),
      .win_o    (wo),
      .desync_o (desync)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input cv_t obs, input cv_t exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [271:0] mkwin(input int t0, t1, t2, m0, m1, m2, b0, b1, b2);
      logic [8:0][29:0] p;
      p[0] = 30'(t0); p[1] = 30'(t1); p[2] = 30'(t2);
      p[3] = 30'(m0); p[4] = 30'(m1); p[5] = 30'(m2);
      p[6] = 30'(b0); p[7] = 30'(b1); p[8] = 30'(b2);
      return {2'b00, p};
   endfunction

   function automatic int px(input int ln, input int r, input int x);
      return ln * 100000 + r * 10000 + x;
   endfunction

   // Capture transfers and check hold-while-stalled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev <= 1'b0;
      end else begin
         if (wo.tvalid && wo.tready) q.push_back({wo.tuser, wo.tlast, wo.tdata});
         if (stall_prev) chk("hold", {wo.tuser, wo.tlast, wo.tdata}, prev_out);
         stall_prev <= wo.tvalid && !wo.tready;
         prev_out   <= {wo.tuser, wo.tlast, wo.tdata};
      end
   end

   always @(negedge clk) begin
      if (rand_on) chk("tready_eq", cv_t'({r0.tready, r2.tready}), cv_t'({r1.tready, r1.tready}));
   end

   task automatic set_row(input int r, input logic v, input int d, input logic u, input logic l);
      case (r)
         0: begin r0.tvalid = v; r0.tdata = 32'(d); r0.tuser = u; r0.tlast = l; end
         1: begin r1.tvalid = v; r1.tdata = 32'(d); r1.tuser = u; r1.tlast = l; end
         default: begin r2.tvalid = v; r2.tdata = 32'(d); r2.tuser = u; r2.tlast = l; end
      endcase
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One column on all rows at once; returns #1 after the accepting edge.
   task automatic send(input int t, m, b, input logic usr, input logic l0, l1, l2);
      int k;
      set_row(0, 1'b1, t, usr, l0);
      set_row(1, 1'b1, m, usr, l1);
      set_row(2, 1'b1, b, usr, l2);
      k = 0;
      @(negedge clk);
      while (!r1.tready && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("send_rdy", cv_t'(r1.tready), cv_t'(1));
      @(posedge clk);
      #1;
      for (int r = 0; r < 3; r++) set_row(r, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic drive_row(input int r, input int ln, input int n);
      int k;
      int gap;
      for (int x = 0; x < n; x++) begin
         gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         set_row(r, 1'b0, 0, 1'b0, 1'b0);
         repeat (gap) begin @(posedge clk); #1; end
         set_row(r, 1'b1, px(ln, r, x), (ln == 0 && x == 0), (x == n - 1));
         k = 0;
         @(negedge clk);
         while (!(r0.tvalid && r1.tvalid && r2.tvalid && r1.tready) && k < 1000) begin
            @(negedge clk);
            k++;
         end
         chk("row_accept", cv_t'(r0.tvalid && r1.tvalid && r2.tvalid && r1.tready), cv_t'(1));
         @(posedge clk);
         #1;
      end
      set_row(r, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic chk_win(input string tag, input int idx, input logic [271:0] d, input logic u, input logic l);
      if (idx < q.size()) chk(tag, cv_t'(q[idx]), {u, l, d});
      else chk({tag, "_present"}, cv_t'(q.size()), cv_t'(idx + 1));
   endtask

   initial begin
      rst_n = 1'b0;
      wo.tready = 1'b1;
      for (int r = 0; r < 3; r++) set_row(r, 1'b0, 0, 1'b0, 1'b0);
      tick(3);
      chk("rst_tvalid", cv_t'(wo.tvalid), cv_t'(0));
      chk("rst_tlast", cv_t'(wo.tlast), cv_t'(0));
      chk("rst_tuser", cv_t'(wo.tuser), cv_t'(0));
      chk("rst_tdata", cv_t'(wo.tdata), cv_t'(0));
      chk("rst_desync", cv_t'(desync), cv_t'(0));
      rst_n = 1'b1;
      tick(2);

      // 4-pixel line with start-of-frame
      q.delete();
      send(10, 20, 30, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t4_lat0", cv_t'(wo.tvalid), cv_t'(0));
      send(11, 21, 31, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t4_lat1", cv_t'(wo.tvalid), cv_t'(1));
      send(12, 22, 32, 1'b0, 1'b0, 1'b0, 1'b0);
      send(13, 23, 33, 1'b0, 1'b1, 1'b1, 1'b1);
      tick(4);
      chk("t4_count", cv_t'(q.size()), cv_t'(4));
      chk_win("t4_w0", 0, mkwin(10, 10, 11, 20, 20, 21, 30, 30, 31), 1'b1, 1'b0);
      chk_win("t4_w1", 1, mkwin(10, 11, 12, 20, 21, 22, 30, 31, 32), 1'b0, 1'b0);
      chk_win("t4_w2", 2, mkwin(11, 12, 13, 21, 22, 23, 31, 32, 33), 1'b0, 1'b0);
      chk_win("t4_w3", 3, mkwin(12, 13, 13, 22, 23, 23, 32, 33, 33), 1'b0, 1'b1);

      // 1-pixel line
      q.delete();
      send(5, 6, 7, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(3);
      chk("t1_count", cv_t'(q.size()), cv_t'(1));
      chk_win("t1_w0", 0, mkwin(5, 5, 5, 6, 6, 6, 7, 7, 7), 1'b1, 1'b1);

      // row1 ends at pixel 3, row0 at pixel 4
      q.delete();
      send(40, 50, 60, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ds_p1", cv_t'(desync), cv_t'(0));
      send(41, 51, 61, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ds_p2", cv_t'(desync), cv_t'(0));
      send(42, 52, 62, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("ds_p3", cv_t'(desync), cv_t'(1));
      tick(1);
      chk("ds_p3_end", cv_t'(desync), cv_t'(0));
      send(43, 53, 63, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("ds_p4", cv_t'(desync), cv_t'(0));
      tick(3);
      chk("ds_count", cv_t'(q.size()), cv_t'(4));
      chk_win("ds_w0", 0, mkwin(40, 40, 41, 50, 50, 51, 60, 60, 61), 1'b0, 1'b0);
      chk_win("ds_w1", 1, mkwin(40, 41, 42, 50, 51, 52, 60, 61, 62), 1'b0, 1'b0);
      chk_win("ds_w2", 2, mkwin(41, 42, 42, 51, 52, 52, 61, 62, 62), 1'b0, 1'b1);
      chk_win("ds_w3", 3, mkwin(43, 43, 43, 53, 53, 53, 63, 63, 63), 1'b0, 1'b1);

      // mid-line tuser on the 8th column restarts the line
      q.delete();
      for (int k = 0; k < 7; k++) send(100 + k, 200 + k, 300 + k, (k == 0), 1'b0, 1'b0, 1'b0);
      send(150, 250, 350, 1'b1, 1'b0, 1'b0, 1'b0);
      send(151, 251, 351, 1'b0, 1'b0, 1'b0, 1'b0);
      send(152, 252, 352, 1'b0, 1'b0, 1'b0, 1'b0);
      send(153, 253, 353, 1'b0, 1'b1, 1'b1, 1'b1);
      tick(3);
      chk("ml_count", cv_t'(q.size()), cv_t'(10));
      chk_win("ml_w0", 0, mkwin(100, 100, 101, 200, 200, 201, 300, 300, 301), 1'b1, 1'b0);
      chk_win("ml_w5", 5, mkwin(104, 105, 106, 204, 205, 206, 304, 305, 306), 1'b0, 1'b0);
      chk_win("ml_w6", 6, mkwin(150, 150, 151, 250, 250, 251, 350, 350, 351), 1'b1, 1'b0);
      chk_win("ml_w8", 8, mkwin(151, 152, 153, 251, 252, 253, 351, 352, 353), 1'b0, 1'b0);
      chk_win("ml_w9", 9, mkwin(152, 153, 153, 252, 253, 253, 352, 353, 353), 1'b0, 1'b1);

      // async reset while a window is held
      q.delete();
      wo.tready = 1'b0;
      send(1, 2, 3, 1'b1, 1'b0, 1'b0, 1'b0);
      send(4, 5, 6, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ar_held", cv_t'(wo.tvalid), cv_t'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_tvalid", cv_t'(wo.tvalid), cv_t'(0));
      chk("ar_tdata", cv_t'(wo.tdata), cv_t'(0));
      tick(1);
      rst_n = 1'b1;
      wo.tready = 1'b1;
      tick(1);
      chk("ar_idle", cv_t'(wo.tvalid), cv_t'(0));
      send(7, 8, 9, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ar_one_col", cv_t'(wo.tvalid), cv_t'(0));
      send(10, 11, 12, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ar_two_col", cv_t'({wo.tvalid, wo.tdata}), cv_t'({1'b1, mkwin(7, 7, 10, 8, 8, 11, 9, 9, 12)}));
      send(13, 14, 15, 1'b0, 1'b1, 1'b1, 1'b1);
      tick(3);

      // two full lines with random input gaps and output backpressure
      q.delete();
      rand_on = 1'b1;
      fork
         begin
            for (int ln = 0; ln < 2; ln++) begin
               fork
                  drive_row(0, ln, LINE_N);
                  drive_row(1, ln, LINE_N);
                  drive_row(2, ln, LINE_N);
               join
            end
            rand_on = 1'b0;
         end
         begin
            while (rand_on) begin
               @(posedge clk);
               #1;
               wo.tready = ($urandom_range(0, 2) != 0);
            end
         end
      join
      wo.tready = 1'b1;
      tick(6);
      chk("rnd_count", cv_t'(q.size()), cv_t'(2 * LINE_N));
      chk("rnd_desync", cv_t'(desync), cv_t'(0));
      for (int ln = 0; ln < 2; ln++) begin
         for (int x = 0; x < LINE_N; x++) begin
            int xl;
            int xr;
            xl = (x == 0) ? 0 : x - 1;
            xr = (x == LINE_N - 1) ? x : x + 1;
            chk_win("rnd_win", ln * LINE_N + x,
                    mkwin(px(ln, 0, xl), px(ln, 0, x), px(ln, 0, xr),
                          px(ln, 1, xl), px(ln, 1, x), px(ln, 1, xr),
                          px(ln, 2, xl), px(ln, 2, x), px(ln, 2, xr)),
                    (ln == 0 && x == 0), (x == LINE_N - 1));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
